// File: rtl/count_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencer/checker.
package count_seq_ctrl_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int LEN_W_DEF = 8;
    // Cycles from the set strobe until the counter presents the loaded number.
    localparam int CNT_LAT   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

endpackage

// File: rtl/count_seq_cmp.sv
// Expected-value generator and compare/record datapath for one checked run.
module count_seq_cmp
    import count_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_init,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [CNT_W-1:0] i_number,
    input  logic             i_zero,
    output logic             o_last,
    output logic             o_err,
    output logic [LEN_W-1:0] o_err_idx,
    output logic [LEN_W-1:0] o_wraps
);

    logic [CNT_W-1:0] r_exp;
    logic [LEN_W-1:0] r_idx;
    logic             r_err;
    logic [LEN_W-1:0] r_err_idx;
    logic [LEN_W-1:0] r_wraps;
    logic             w_fail;

    assign w_fail = (i_number != r_exp) || (i_zero != (r_exp == '0));
    assign o_last = (r_idx == i_len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_exp     <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_wraps   <= '0;
        end else begin
            if (i_init)
                r_exp <= i_start;
            if (i_en) begin
                r_exp <= r_exp + CNT_W'(1);
                r_idx <= r_idx + LEN_W'(1);
                // Only the first failing sample is recorded.
                if (w_fail && !r_err) begin
                    r_err     <= 1'b1;
                    r_err_idx <= r_idx;
                end
                if (i_zero && (r_wraps != '1))
                    r_wraps <= r_wraps + LEN_W'(1);
            end
        end
    end

    assign o_err     = r_err;
    assign o_err_idx = r_err_idx;
    assign o_wraps   = r_wraps;

endmodule

// File: rtl/count_seq_ctrl.sv
// Run sequencer: loads the counter with a set pulse, then checks its number/zero stream.
module count_seq_ctrl
    import count_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_start,
    input  logic [LEN_W-1:0] req_len,
    output logic             set,
    output logic [CNT_W-1:0] set_num,
    input  logic [CNT_W-1:0] number,
    input  logic             zero,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] err_idx,
    output logic [LEN_W-1:0] wraps
);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic             r_set;
    logic [CNT_W-1:0] r_set_num;
    logic [1:0]       r_wcnt;
    logic             w_accept;
    logic             w_wait_end;
    logic             w_last;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    // WAIT spans the counter latency minus the LOAD cycle itself.
    assign w_wait_end = (r_wcnt == 2'(CNT_LAT - 2));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  if (w_wait_end) w_next = (r_len != '0) ? S_CHECK : S_DONE;
            S_CHECK: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_set     <= 1'b0;
            r_set_num <= '0;
            r_len     <= '0;
            r_wcnt    <= '0;
        end else begin
            r_set <= w_accept;
            if (w_accept) begin
                r_set_num <= req_start;
                r_len     <= req_len;
            end
            r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 2'd1 : 2'd0;
        end
    end

    count_seq_cmp #(
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_init    (r_state == S_WAIT),
        .i_en      (r_state == S_CHECK),
        .i_start   (r_set_num),
        .i_len     (r_len),
        .i_number  (number),
        .i_zero    (zero),
        .o_last    (w_last),
        .o_err     (err),
        .o_err_idx (err_idx),
        .o_wraps   (wraps)
    );

    assign req_ready = (r_state == S_IDLE);
    assign set       = r_set;
    assign set_num   = r_set_num;
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: behavioural counter with per-sample fault injection.
module tb_count_seq_ctrl;

    localparam int CNT_W = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_start;
    logic [LEN_W-1:0] req_len;
    logic             set;
    logic [CNT_W-1:0] set_num;
    logic [CNT_W-1:0] number;
    logic             zero;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] err_idx;
    logic [LEN_W-1:0] wraps;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_seq_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_start(req_start), .req_len(req_len), .set(set), .set_num(set_num),
        .number(number), .zero(zero), .done(done), .err(err),
        .err_idx(err_idx), .wraps(wraps)
    );

    // Two-stage loadable counter: num register, then number/zero register.
    logic [3:0] c_num = 4'd0;
    logic [3:0] c_number = 4'd0;
    logic       c_zero = 1'b0;
    int         since_set = 1000;

    always @(posedge clk) begin
        c_num     <= set ? set_num : c_num + 4'd1;
        c_number  <= c_num;
        c_zero    <= (c_num == 4'd0);
        since_set <= set ? 0 : ((since_set < 1000) ? since_set + 1 : since_set);
    end

    // Per-sample overrides; sample k reaches the DUT when since_set == k+1.
    bit         fn_en [16];
    logic [3:0] fn_val[16];
    bit         fz_en [16];
    logic       fz_val[16];
    int         fk;

    always_comb begin
        number = c_number;
        zero   = c_zero;
        fk     = since_set - 1;
        if (fk >= 0 && fk < 16) begin
            if (fn_en[fk]) number = fn_val[fk];
            if (fz_en[fk]) zero = fz_val[fk];
        end
    end

    task automatic clear_forces();
        for (int i = 0; i < 16; i++) begin
            fn_en[i] = 1'b0; fn_val[i] = 4'd0; fz_en[i] = 1'b0; fz_val[i] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference result computed directly from the run rules over sample indices.
    task automatic model(input int st, input int ln, output logic e, output int ei, output int w);
        int ev, n;
        logic z;
        e = 1'b0; ei = 0; w = 0;
        for (int k = 0; k < ln; k++) begin
            ev = (st + k) % 16;
            n  = ev;
            z  = (ev == 0);
            if (k < 16 && fn_en[k]) n = int'(fn_val[k]);
            if (k < 16 && fz_en[k]) z = fz_val[k];
            if ((n != ev || z != (ev == 0)) && !e) begin
                e = 1'b1; ei = k;
            end
            if (z && w < 255) w++;
        end
    endtask

    // Issue one request and follow it to done; cycle 1 is the cycle after the accept edge.
    task automatic do_run(input logic [3:0] st, input logic [7:0] ln, input bit hold,
                          output int dcyc, output logic e, output logic [7:0] ei,
                          output logic [7:0] w, output bit seq_ok);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_start = st; req_len = ln;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk); n++;
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        dcyc = -1; e = 1'bx; ei = 'x; w = 'x; seq_ok = 1'b1;
        for (int c = 1; c <= int'(ln) + 10; c++) begin
            @(negedge clk);
            if (set !== (c == 1)) seq_ok = 1'b0;
            if (c == 1 && set_num !== st) seq_ok = 1'b0;
            if (req_ready !== 1'b0) seq_ok = 1'b0;
            if (done === 1'b1) begin
                dcyc = c; e = err; ei = err_idx; w = wraps;
                break;
            end
        end
    endtask

    typedef struct {
        int   st;
        int   ln;
        int   f1k;
        int   f1n;
        int   f2k;
        int   f2n;
        int   fzk;
        logic e;
        int   ei;
        int   w;
    } vec_t;

    vec_t       tbl[7];
    int         dcyc, mei, mw, n;
    logic       ge, me;
    logic [7:0] gei, gw;
    bit         sok;
    int         rs, rl;

    initial begin
        tbl[0] = '{3,  5, -1, 0, -1, 0, -1, 1'b0, 0, 0};
        tbl[1] = '{14, 4, -1, 0, -1, 0, -1, 1'b0, 0, 1};
        tbl[2] = '{0,  1, -1, 0, -1, 0, -1, 1'b0, 0, 1};
        tbl[3] = '{5,  4,  2, 9, -1, 0, -1, 1'b1, 2, 0};
        tbl[4] = '{5,  4,  2, 9,  3, 9, -1, 1'b1, 2, 0};
        tbl[5] = '{4,  3, -1, 0, -1, 0,  0, 1'b1, 0, 1};
        tbl[6] = '{7,  0, -1, 0, -1, 0, -1, 1'b0, 0, 0};

        clear_forces();
        rst = 1'b1; req_valid = 1'b0; req_start = '0; req_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_set", 32'(set), 32'd0);
        chk("rst_set_num", 32'(set_num), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_err", 32'({err, err_idx, wraps}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            clear_forces();
            if (tbl[i].f1k >= 0) begin fn_en[tbl[i].f1k] = 1'b1; fn_val[tbl[i].f1k] = 4'(tbl[i].f1n); end
            if (tbl[i].f2k >= 0) begin fn_en[tbl[i].f2k] = 1'b1; fn_val[tbl[i].f2k] = 4'(tbl[i].f2n); end
            if (tbl[i].fzk >= 0) begin fz_en[tbl[i].fzk] = 1'b1; fz_val[tbl[i].fzk] = 1'b1; end
            do_run(4'(tbl[i].st), 8'(tbl[i].ln), 1'b0, dcyc, ge, gei, gw, sok);
            chk($sformatf("tbl%0d_done_cyc", i), 32'(dcyc), 32'(3 + tbl[i].ln));
            chk($sformatf("tbl%0d_seq", i), 32'(sok), 32'd1);
            chk($sformatf("tbl%0d_err", i), 32'(ge), 32'(tbl[i].e));
            chk($sformatf("tbl%0d_err_idx", i), 32'(gei), 32'(tbl[i].ei));
            chk($sformatf("tbl%0d_wraps", i), 32'(gw), 32'(tbl[i].w));
        end

        // Results hold after done until the next accept.
        @(negedge clk);
        chk("hold_after_done", 32'({err, wraps}), 32'd0);

        // req_valid held high through a len=0 run is only taken again once idle.
        clear_forces();
        do_run(4'd7, 8'd0, 1'b1, dcyc, ge, gei, gw, sok);
        chk("hold_done_cyc", 32'(dcyc), 32'd3);
        chk("hold_seq", 32'(sok), 32'd1);
        @(negedge clk);
        chk("hold_ready_idle", 32'({req_ready, set}), 32'b10);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("hold_reaccept_set", 32'({set, set_num}), 32'({1'b1, 4'd7}));
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk); n++;
        end
        chk("hold_second_done", 32'(done), 32'd1);

        // Reset during the second CHECK cycle of a run that has already failed sample 0.
        clear_forces();
        fn_en[0] = 1'b1; fn_val[0] = 4'd3;
        @(negedge clk);
        req_valid = 1'b1; req_start = 4'd0; req_len = 8'd5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_err_wraps", 32'({err, err_idx, wraps}), 32'({1'b1, 8'd0, 8'd1}));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_set_done", 32'({set, done}), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_err_wraps", 32'({err, err_idx, wraps}), 32'd0);
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) chk("abort_no_done", 32'(done), 32'd0);
        end
        clear_forces();
        do_run(4'd2, 8'd3, 1'b0, dcyc, ge, gei, gw, sok);
        chk("post_rst_done_cyc", 32'(dcyc), 32'd6);
        chk("post_rst_result", 32'({ge, gei, gw, sok}), 32'({1'b0, 8'd0, 8'd0, 1'b1}));

        // Randomized runs with sparse injected faults against the reference model.
        for (int r = 0; r < 40; r++) begin
            clear_forces();
            rs = int'($urandom_range(0, 15));
            rl = int'($urandom_range(0, 40));
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 7) == 0) begin fn_en[k] = 1'b1; fn_val[k] = 4'($urandom_range(0, 15)); end
                if ($urandom_range(0, 9) == 0) begin fz_en[k] = 1'b1; fz_val[k] = 1'($urandom_range(0, 1)); end
            end
            model(rs, rl, me, mei, mw);
            do_run(4'(rs), 8'(rl), 1'b0, dcyc, ge, gei, gw, sok);
            chk($sformatf("rnd%0d_done_cyc", r), 32'(dcyc), 32'(3 + rl));
            chk($sformatf("rnd%0d_seq", r), 32'(sok), 32'd1);
            chk($sformatf("rnd%0d_err", r), 32'(ge), 32'(me));
            chk($sformatf("rnd%0d_err_idx", r), 32'(gei), 32'(mei));
            chk($sformatf("rnd%0d_wraps", r), 32'(gw), 32'(mw));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
